// File: rtl/dyn_console_ctrl.sv
// Text-console controller: turns a received byte stream into VRAM writes,
// cursor movement, hardware scrolling through a rotating row base, and
// multi-cycle line/screen clears.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | accepting bytes, at most one VRAM write per accepted byte
// CLR_LINE   | blanking the row that just scrolled in at the bottom
// CLR_SCREEN | blanking the whole page (after reset or form feed)
module dyn_console_ctrl #(
  parameter int          COLS       = 40,
  parameter int          ROWS       = 30,
  parameter int          ADDR_W     = 13,
  parameter int          TAB_W      = 8,
  parameter int          SCROLL     = 1,
  parameter int          CLR_ON_RST = 1,
  parameter logic [7:0]  BLANK      = 8'h20,
  localparam int         XW         = $clog2(COLS),
  localparam int         YW         = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic [XW-1:0]     cursor_x,
  output logic [YW-1:0]     cursor_y,
  output logic [YW-1:0]     row_base,
  output logic              vram_we,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, CLR_LINE = 2'd1, CLR_SCREEN = 2'd2} state_t;

  localparam state_t            RST_STATE   = (CLR_ON_RST != 0) ? CLR_SCREEN : IDLE;
  localparam logic [XW-1:0]     X_LAST      = XW'(COLS - 1);
  localparam logic [XW-1:0]     X_ONE       = XW'(1);
  localparam logic [YW-1:0]     Y_LAST      = YW'(ROWS - 1);
  localparam logic [YW-1:0]     Y_ONE       = YW'(1);
  localparam logic [XW:0]       COLS_W      = (XW + 1)'(COLS);
  localparam logic [XW:0]       TAB_MASK    = (XW + 1)'(TAB_W - 1);
  localparam logic [XW:0]       TAB_ONE     = (XW + 1)'(1);
  localparam logic [YW:0]       ROWS_W      = (YW + 1)'(ROWS);
  localparam logic [ADDR_W-1:0] A_COLS      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] A_ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_LINE_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] A_SCR_LAST  = ADDR_W'(COLS * ROWS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [ADDR_W-1:0] line_base, line_nxt;
  logic [XW-1:0]     x_nxt;
  logic [YW-1:0]     y_nxt, base_nxt;
  logic              we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [7:0]        data_nxt;
  logic              do_nl;

  logic [YW:0]       row_sum, phys_row;
  logic [ADDR_W-1:0] row_addr, cur_addr;
  logic [XW:0]       tab_next;
  logic              accept;
  logic              printable;

  // logical row + base can reach 2*ROWS-2, so one conditional subtract folds it
  assign row_sum   = {1'b0, cursor_y} + {1'b0, row_base};
  assign phys_row  = (row_sum >= ROWS_W) ? row_sum - ROWS_W : row_sum;
  assign row_addr  = ADDR_W'(phys_row) * A_COLS;
  assign cur_addr  = row_addr + ADDR_W'(cursor_x);
  assign tab_next  = ({1'b0, cursor_x} | TAB_MASK) + TAB_ONE;
  assign accept    = in_valid && in_ready;
  assign printable = (in_data >= 8'h20) && (in_data != 8'h7F);

  // state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= RST_STATE;
    else       state <= state_nxt;
  end

  // next-state and next-datapath decode
  always_comb begin
    state_nxt = state;
    x_nxt     = cursor_x;
    y_nxt     = cursor_y;
    base_nxt  = row_base;
    cnt_nxt   = cnt;
    line_nxt  = line_base;
    we_nxt    = 1'b0;
    addr_nxt  = vram_addr;
    data_nxt  = vram_data;
    do_nl     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (printable) begin
            we_nxt   = 1'b1;
            addr_nxt = cur_addr;
            data_nxt = in_data;
            if (cursor_x == X_LAST) do_nl = 1'b1;
            else                    x_nxt = cursor_x + X_ONE;
          end else begin
            case (in_data)
              8'h08: if (cursor_x != '0) begin
                x_nxt    = cursor_x - X_ONE;
                we_nxt   = 1'b1;
                addr_nxt = cur_addr - A_ONE;
                data_nxt = BLANK;
              end
              8'h7F: begin
                we_nxt   = 1'b1;
                addr_nxt = cur_addr;
                data_nxt = BLANK;
              end
              8'h09: begin
                if (tab_next >= COLS_W) do_nl = 1'b1;
                else                    x_nxt = tab_next[XW-1:0];
              end
              8'h0D: x_nxt = '0;
              8'h0A: do_nl = 1'b1;
              8'h0C: begin
                x_nxt     = '0;
                y_nxt     = '0;
                base_nxt  = '0;
                cnt_nxt   = '0;
                state_nxt = CLR_SCREEN;
              end
              8'h11: if (cursor_x != '0)     x_nxt = cursor_x - X_ONE;
              8'h12: if (cursor_x != X_LAST) x_nxt = cursor_x + X_ONE;
              8'h13: if (cursor_y != '0)     y_nxt = cursor_y - Y_ONE;
              8'h14: if (cursor_y != Y_LAST) y_nxt = cursor_y + Y_ONE;
              default: ;
            endcase
          end
        end
      end
      CLR_LINE: begin
        we_nxt   = 1'b1;
        addr_nxt = line_base + cnt;
        data_nxt = BLANK;
        if (cnt == A_LINE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + A_ONE;
        end
      end
      CLR_SCREEN: begin
        we_nxt   = 1'b1;
        addr_nxt = cnt;
        data_nxt = BLANK;
        if (cnt == A_SCR_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + A_ONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // the row leaving the top (old base) becomes the new bottom row and gets blanked
    if (do_nl) begin
      x_nxt = '0;
      if (cursor_y != Y_LAST) begin
        y_nxt = cursor_y + Y_ONE;
      end else if (SCROLL != 0) begin
        base_nxt  = (row_base == Y_LAST) ? '0 : row_base + Y_ONE;
        line_nxt  = ADDR_W'(row_base) * A_COLS;
        cnt_nxt   = '0;
        state_nxt = CLR_LINE;
      end else begin
        y_nxt = '0;
      end
    end
  end

  // cursor, scroll base, clear counters and registered VRAM port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cursor_x  <= '0;
      cursor_y  <= '0;
      row_base  <= '0;
      cnt       <= '0;
      line_base <= '0;
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      cursor_x  <= x_nxt;
      cursor_y  <= y_nxt;
      row_base  <= base_nxt;
      cnt       <= cnt_nxt;
      line_base <= line_nxt;
      vram_we   <= we_nxt;
      vram_addr <= addr_nxt;
      vram_data <= data_nxt;
    end
  end

  // handshake and status outputs
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
  end

endmodule
